// File: rtl/pipeline_sequencer_pkg.sv
// Shared types and defaults for the pipeline sequencer.
package pipeline_sequencer_pkg;

  localparam int STATE_W       = 2;
  localparam int DEF_NUM_PIPES = 2;
  localparam int DEF_STAGGER_W = 8;

  typedef enum logic [STATE_W-1:0] {
    IDLE      = 2'd0,
    RAMP_UP   = 2'd1,
    RUN       = 2'd2,
    RAMP_DOWN = 2'd3
  } seq_state_t;

endpackage

// File: rtl/pipeline_sequencer_seq_step_timer.sv
// Step timer: saturating cycle counter plus a tick-qualified step strobe.
// The counter only advances while active and restarts on clear or on a step.
module seq_step_timer
  import pipeline_sequencer_pkg::*;
#(
  parameter int STAGGER_W = DEF_STAGGER_W
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 active,
  input  logic                 clear,
  input  logic                 tick,
  input  logic [STAGGER_W-1:0] stagger,
  output logic                 step
);

  logic [STAGGER_W-1:0] cnt;

  assign step = active && tick && (cnt >= stagger);

  // Count cycles since the last step or state entry, holding at all-ones.
  always_ff @(posedge clock) begin
    if (reset) begin
      cnt <= '0;
    end else if (clear || step) begin
      cnt <= '0;
    end else if (active && (cnt != '1)) begin
      cnt <= cnt + STAGGER_W'(1);
    end
  end

endmodule

// File: rtl/pipeline_sequencer.sv
// Pipeline sequencer: turns per-pipe half-rate enables on one at a time
// (lowest index first) and off one at a time (highest index first), with a
// minimum stagger between steps and each step aligned to one_half_tick.
// Optional feature macro: ONE_FORTH_COUNTER_EN adds a quarter-rate enable
// mirror that ramp-down completion also waits on.
//
// state     | meaning
// IDLE      | all enables off, waiting for start with a non-empty mask
// RAMP_UP   | enabling masked pipes one per step
// RUN       | all masked pipes enabled, waiting for stop
// RAMP_DOWN | disabling enabled pipes one per step
module pipeline_sequencer
  import pipeline_sequencer_pkg::*;
#(
  parameter int NUM_PIPES = DEF_NUM_PIPES,
  parameter int STAGGER_W = DEF_STAGGER_W
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 stop,
  input  logic [NUM_PIPES-1:0] pipe_mask,
  input  logic [STAGGER_W-1:0] stagger_cycles,
  input  logic                 one_half_tick,
  output logic [NUM_PIPES-1:0] one_half_pipe_enable,
`ifdef ONE_FORTH_COUNTER_EN
  input  logic                 one_forth_tick,
  output logic [NUM_PIPES-1:0] one_forth_pipe_enable,
`endif
  output logic                 busy,
  output logic                 done,
  output logic [STATE_W-1:0]   seq_state
);

  seq_state_t           state, state_next;
  logic [NUM_PIPES-1:0] en, en_next, mask_q, lo_hot, hi_hot, en_up, en_dn, en_step_dn;
  logic [STAGGER_W-1:0] stagger_q;
  logic                 done_next, step, active, clear, start_ok, all_clear;

  assign start_ok = start && (pipe_mask != '0);
  assign active   = (state == RAMP_UP) || (state == RAMP_DOWN);
  assign clear    = (state_next != state);

  seq_step_timer #(.STAGGER_W(STAGGER_W)) u_timer (
    .clock   (clock),
    .reset   (reset),
    .active  (active),
    .clear   (clear),
    .tick    (one_half_tick),
    .stagger (stagger_q),
    .step    (step)
  );

  // Select the next pipe to turn on (lowest pending) and off (highest enabled).
  always_comb begin
    lo_hot = '0;
    hi_hot = '0;
    for (int i = NUM_PIPES - 1; i >= 0; i--) begin
      if (mask_q[i] && !en[i]) begin
        lo_hot    = '0;
        lo_hot[i] = 1'b1;
      end
    end
    for (int i = 0; i < NUM_PIPES; i++) begin
      if (en[i]) begin
        hi_hot    = '0;
        hi_hot[i] = 1'b1;
      end
    end
  end

  assign en_up      = en | lo_hot;
  assign en_dn      = en & ~hi_hot;
  assign en_step_dn = step ? en_dn : en;

`ifdef ONE_FORTH_COUNTER_EN
  logic [NUM_PIPES-1:0] forth_next;

  assign forth_next = one_forth_tick ? en : one_forth_pipe_enable;
  assign all_clear  = (en_step_dn == '0) && (forth_next == '0);

  // Quarter-rate mirror of the half-rate enables, refreshed on forth ticks.
  always_ff @(posedge clock) begin
    if (reset) begin
      one_forth_pipe_enable <= '0;
    end else begin
      one_forth_pipe_enable <= forth_next;
    end
  end
`else
  assign all_clear = (en_step_dn == '0);
`endif

  // State register plus the registered enables, done pulse and latched config.
  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      en        <= '0;
      done      <= 1'b0;
      mask_q    <= '0;
      stagger_q <= '0;
    end else begin
      state <= state_next;
      en    <= en_next;
      done  <= done_next;
      if ((state == IDLE) && start_ok) begin
        mask_q    <= pipe_mask;
        stagger_q <= stagger_cycles;
      end
    end
  end

  // Next-state decode; stop takes priority over a coincident step in RAMP_UP.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:      if (start_ok) state_next = RAMP_UP;
      RAMP_UP: begin
        if (stop) begin
          state_next = (en == '0) ? IDLE : RAMP_DOWN;
        end else if (step && (en_up == mask_q)) begin
          state_next = RUN;
        end
      end
      RUN:       if (stop) state_next = RAMP_DOWN;
      RAMP_DOWN: if (all_clear) state_next = IDLE;
      default:   state_next = IDLE;
    endcase
  end

  // Output decode: next enables, done on ramp completion, status.
  always_comb begin
    en_next = en;
    case (state)
      RAMP_UP:   if (!stop && step) en_next = en_up;
      RAMP_DOWN: en_next = en_step_dn;
      default:   en_next = en;
    endcase
    done_next = ((state == RAMP_UP) && (state_next == RUN)) ||
                ((state != IDLE) && (state_next == IDLE));
    busy      = (state != IDLE);
    seq_state = state;
  end

  assign one_half_pipe_enable = en;

endmodule

// File: tb/tb_pipeline_sequencer.sv
// Scoreboard bench for pipeline_sequencer: each scenario's expected enable
// changes and done pulses are computed from the ramp rules and queued; a
// monitor pops and compares whenever the enables change or done pulses.
module tb_pipeline_sequencer;
  localparam int NP   = 3;
  localparam int SW   = 4;
  localparam int MAXR = 1024;

  logic          clock = 1'b0;
  logic          reset, start, stop, one_half_tick;
  logic [NP-1:0] pipe_mask;
  logic [SW-1:0] stagger_cycles;
  logic [NP-1:0] one_half_pipe_enable;
  logic          busy, done;
  logic [1:0]    seq_state;
`ifdef ONE_FORTH_COUNTER_EN
  logic          one_forth_tick = 1'b0;
  logic [NP-1:0] one_forth_pipe_enable;
  logic [NP-1:0] prev_forth = '0;
`endif

  pipeline_sequencer #(.NUM_PIPES(NP), .STAGGER_W(SW)) dut (
    .clock                (clock),
    .reset                (reset),
    .start                (start),
    .stop                 (stop),
    .pipe_mask            (pipe_mask),
    .stagger_cycles       (stagger_cycles),
    .one_half_tick        (one_half_tick),
    .one_half_pipe_enable (one_half_pipe_enable),
`ifdef ONE_FORTH_COUNTER_EN
    .one_forth_tick        (one_forth_tick),
    .one_forth_pipe_enable (one_forth_pipe_enable),
`endif
    .busy                 (busy),
    .done                 (done),
    .seq_state            (seq_state)
  );

  always #5 clock = ~clock;

  typedef struct {
    int            cyc;
    logic [NP-1:0] en;
    logic          dn;
    logic [1:0]    st;
  } ev_t;

  ev_t           exp_q[$];
  ev_t           ev;
  int            checks = 0;
  int            errors = 0;
  int            cyc = 0;
  bit            sb_en = 1'b0;
  logic [NP-1:0] prev_en = '0;

  bit            tk[MAXR];
  bit            xs[MAXR];
  bit            xp[MAXR];
  logic [NP-1:0] en_rel[MAXR];

  always @(posedge clock) cyc <= cyc + 1;

`ifdef ONE_FORTH_COUNTER_EN
  // forth tick sampled at posedge k is high exactly when k is a multiple of 4
  always @(negedge clock) one_forth_tick <= (((cyc + 1) % 4) == 0);
`endif

  // Monitor: pop and compare on every enable change or done pulse.
  always @(negedge clock) begin
    if (sb_en) begin
      if ((one_half_pipe_enable !== prev_en) || (done !== 1'b0)) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_event cyc=%0d en=%b done=%b state=%0d, required no event",
                   cyc, one_half_pipe_enable, done, seq_state);
        end else begin
          ev = exp_q.pop_front();
          if ((ev.cyc != cyc) || (ev.en !== one_half_pipe_enable) ||
              (ev.dn !== done) || (ev.st !== seq_state)) begin
            errors++;
            $display("FAIL event: got cyc=%0d en=%b done=%b state=%0d, required cyc=%0d en=%b done=%b state=%0d",
                     cyc, one_half_pipe_enable, done, seq_state, ev.cyc, ev.en, ev.dn, ev.st);
          end
        end
      end
      checks++;
      if (busy !== (seq_state != 2'd0)) begin
        errors++;
        $display("FAIL busy: got %b with state %0d at cyc=%0d", busy, seq_state, cyc);
      end
`ifdef ONE_FORTH_COUNTER_EN
      checks++;
      if (one_forth_pipe_enable !== (((cyc % 4) == 0) ? prev_en : prev_forth)) begin
        errors++;
        $display("FAIL forth_enable: got %b, required %b at cyc=%0d", one_forth_pipe_enable,
                 (((cyc % 4) == 0) ? prev_en : prev_forth), cyc);
      end
`endif
    end
`ifdef ONE_FORTH_COUNTER_EN
    prev_forth = one_forth_pipe_enable;
`endif
    prev_en = one_half_pipe_enable;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  function automatic void push_ev(input int c, input logic [NP-1:0] e, input logic d, input logic [1:0] st);
    exp_q.push_back('{cyc: c, en: e, dn: d, st: st});
  endfunction

  // First step opportunity: a tick at least stg cycles after the counter restarted.
  function automatic int next_step(input int from, input int stg);
    for (int k = from + stg; k < MAXR; k++) if (tk[k]) return k;
    return MAXR - 1;
  endfunction

  function automatic void mark_en(input int k, input logic [NP-1:0] e);
    for (int r = k; r < MAXR; r++) en_rel[r] = e;
  endfunction

  function automatic bit gen_tick(input int mode, input int r);
    bit t;
    case (mode)
      0:       t = 1'b1;
      1:       t = ((r % 2) == 1);
      2:       t = ($urandom_range(0, 3) == 0);
      default: t = ($urandom_range(0, 23) == 0);
    endcase
    return t || ((r % 64) == 63);
  endfunction

  // One start..completion episode; times are relative to the start-sampling edge.
  task automatic run_scn(input logic [NP-1:0] m, input int stg, input int tmode, input int p);
    int            s, from, k, kend, klast;
    logic [NP-1:0] en;
`ifdef ONE_FORTH_COUNTER_EN
    logic [NP-1:0] f;
    int            rd;
`endif
    for (int r = 0; r < MAXR; r++) begin
      tk[r]     = gen_tick(tmode, r);
      xs[r]     = 1'b0;
      xp[r]     = 1'b0;
      en_rel[r] = '0;
    end
    @(negedge clock);
    s     = cyc + 1;
    en    = '0;
    from  = 1;
    kend  = p;
    klast = p;
    for (int b = 0; b < NP; b++) begin
      if (m[b]) begin
        k = next_step(from, stg);
        if (p <= k) break;
        en[b] = 1'b1;
        from  = k + 1;
        mark_en(k, en);
        push_ev(s + k, en, en == m, (en == m) ? 2'd2 : 2'd1);
      end
    end
    if (m == '0) begin
      kend = p;
    end else if (en == '0) begin
      push_ev(s + p, '0, 1'b1, 2'd0);
      kend = p;
    end else begin
      from = p + 1;
      for (int b = NP - 1; b >= 0; b--) begin
        if (en[b]) begin
          k     = next_step(from, stg);
          en[b] = 1'b0;
          from  = k + 1;
          klast = k;
          mark_en(k, en);
          if (en != '0) push_ev(s + k, en, 1'b0, 2'd3);
        end
      end
`ifdef ONE_FORTH_COUNTER_EN
      f  = '0;
      rd = -1;
      for (int r = 0; (r < MAXR) && (rd < 0); r++) begin
        if (((s + r) % 4) == 0) f = (r == 0) ? '0 : en_rel[r-1];
        if ((r >= klast) && (en_rel[r] == '0) && (f == '0)) rd = r;
      end
      if (rd == klast) begin
        push_ev(s + klast, '0, 1'b1, 2'd0);
      end else begin
        push_ev(s + klast, '0, 1'b0, 2'd3);
        push_ev(s + rd, '0, 1'b1, 2'd0);
      end
      kend = rd;
`else
      push_ev(s + klast, '0, 1'b1, 2'd0);
      kend = klast;
`endif
      for (int r = 1; r <= kend; r++) begin
        xs[r] = ($urandom_range(0, 15) == 0);
        xp[r] = (r > p) && ($urandom_range(0, 15) == 0);
      end
    end
    for (int r = 0; r <= kend + 4; r++) begin
      start          = (r == 0) || xs[r];
      stop           = (r == p) || xp[r];
      one_half_tick  = tk[r];
      pipe_mask      = (r == 0) ? m : NP'($urandom);
      stagger_cycles = (r == 0) ? SW'(stg) : SW'($urandom);
      @(negedge clock);
    end
    start = 1'b0;
    stop  = 1'b0;
    chk("queue_drained", exp_q.size(), 0);
    chk("end_state", seq_state, 2'd0);
    chk("end_busy", busy, 1'b0);
    chk("end_enables", one_half_pipe_enable, '0);
    exp_q.delete();
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; stop = 1'b0; one_half_tick = 1'b0;
    pipe_mask = '0; stagger_cycles = '0;
    repeat (3) @(negedge clock);
    chk("reset_state", seq_state, 2'd0);
    chk("reset_enables", one_half_pipe_enable, '0);
    chk("reset_busy", busy, 1'b0);
    chk("reset_done", done, 1'b0);
    reset = 1'b0;
    @(negedge clock);
    sb_en = 1'b1;

    run_scn(3'b011, 0, 1, 40);   // tick every 2nd cycle, zero stagger
    run_scn(3'b011, 5, 1, 60);   // stagger 5, full up then down
    run_scn(3'b000, 3, 0, 6);    // empty mask: nothing happens
    run_scn(3'b011, 0, 1, 2);    // stop right after first enable
    run_scn(3'b111, 0, 1, 3);    // stop coincides with a step: stop wins
    run_scn(3'b100, 10, 0, 5);   // stop before any enable
    run_scn(3'b111, 15, 3, 200); // max stagger, sparse ticks (saturation)
    run_scn(3'b101, 2, 0, 30);   // gapped mask

    for (int n = 0; n < 40; n++) begin
      run_scn(NP'($urandom_range(0, 7)), $urandom_range(0, 15),
              $urandom_range(0, 3), $urandom_range(1, 60));
    end

    sb_en = 1'b0;
    @(negedge clock);
    start = 1'b1; pipe_mask = 3'b111; stagger_cycles = '0; one_half_tick = 1'b1;
    @(negedge clock);
    start = 1'b0;
    repeat (4) @(negedge clock);
    chk("run_state", seq_state, 2'd2);
    chk("run_enables", one_half_pipe_enable, 3'b111);
    reset = 1'b1; start = 1'b1; stop = 1'b1;
    @(negedge clock);
    chk("midrun_reset_enables", one_half_pipe_enable, '0);
    chk("midrun_reset_state", seq_state, 2'd0);
    chk("midrun_reset_busy", busy, 1'b0);
    chk("midrun_reset_done", done, 1'b0);
`ifdef ONE_FORTH_COUNTER_EN
    chk("midrun_reset_forth", one_forth_pipe_enable, '0);
`endif
    reset = 1'b0; start = 1'b0; stop = 1'b0; one_half_tick = 1'b0;
    @(negedge clock);
    chk("post_reset_state", seq_state, 2'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
